// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Instruction register and Moore controller for the register-file datapath
// Revision : 1.0
// ============================================================================
module instr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic       is_movimm;
    logic       is_movreg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign is_movimm = (opcode == 3'b110) && (op == 2'b10);
    assign is_movreg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu    = (opcode == 3'b101);
    assign is_cmp    = is_alu && (op == 2'b01);
    assign is_mvn    = is_alu && (op == 2'b11);

    assign shift  = ir[4:3];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    // IR is only writable while idle, so fields stay frozen for the whole instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= 16'h0000;
        end else if ((state == S_WAIT) && load) begin
            ir <= in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_WAIT:   if (s) next_state = S_DECODE;
            S_DECODE: begin
                if (is_movimm)                next_state = S_WIMM;
                else if (is_movreg || is_mvn) next_state = S_GETB;
                else if (is_alu)              next_state = S_GETA;
                else                          next_state = S_WAIT;
            end
            S_WIMM:   next_state = S_WAIT;
            S_GETA:   next_state = S_GETB;
            S_GETB:   next_state = S_EXEC;
            S_EXEC:   next_state = is_cmp ? S_WAIT : S_WRITE;
            S_WRITE:  next_state = S_WAIT;
            default:  next_state = S_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = 3'b000;
        writenum = 3'b000;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        ALUop    = 2'b00;
        case (state)
            S_WAIT: w = 1'b1;
            S_WIMM: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
            end
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                // MOV reg passes B through the adder with A forced to zero
                if (is_movreg) begin
                    asel  = 1'b1;
                    loadc = 1'b1;
                end else if (is_cmp) begin
                    ALUop = 2'b01;
                    loads = 1'b1;
                end else begin
                    ALUop = op;
                    loadc = 1'b1;
                end
            end
            S_WRITE: begin
                writenum = rd;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction register plus Moore-state controller that sequences the 8-entry register file and the datapath behind it. It latches a 16-bit instruction and decodes the register fields into `readnum`/`writenum`. It then steps through read-operand, execute and write-back states, issuing one-cycle load and write strobes to the register file, the A/B/C/status registers and the writeback mux. It is the stage directly upstream of the register file: every `readnum`, `writenum` and `write` the register file sees comes from this block.

## Interface
- Parameters: none.
- Reset is asynchronous, active-high; one clock, all state on its rising edge.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  16  instruction word.
- load  input  1  latch `in` into the instruction register (IR); honoured only in WAIT.
- s  input  1  start execution of the IR contents; honoured only in WAIT.
- w  output  1  high only in WAIT (idle, ready for `load`/`s`).
- readnum  output  3  register-file read select.
- writenum  output  3  register-file write select.
- write  output  1  register-file write strobe.
- loada, loadb, loadc, loads  output  1 each  load enables for A, B, C and status registers.
- asel  output  1  1 selects zero instead of A at the ALU A input.
- bsel  output  1  1 selects sximm5 instead of shifted B.
- vsel  output  2  writeback source: 00 = C, 10 = sximm8; 01 and 11 are reserved and never driven.
- ALUop  output  2  ALU operation (00 add, 01 sub, 10 and, 11 not-B).
- shift  output  2  IR[4:3], always.
- sximm8  output  16  IR[7:0] sign-extended.
- sximm5  output  16  IR[4:0] sign-extended.

## Operation
- IR fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0].
- Legal instructions:
  - MOV imm = 110/10.
  - MOV reg = 110/00.
  - ADD = 101/00, CMP = 101/01, AND = 101/10, MVN = 101/11.
  - Every other opcode/op combination is illegal.
- States: WAIT, DECODE, WIMM, GETA, GETB, EXEC, WRITE.
- Transitions:
  - WAIT: to DECODE if `s`, else stay.
  - DECODE:
    - MOV imm to WIMM.
    - MOV reg and MVN to GETB.
    - ADD/CMP/AND to GETA.
    - Illegal to WAIT, with no strobes issued.
  - WIMM to WAIT.
  - GETA to GETB.
  - GETB to EXEC.
  - EXEC: CMP to WAIT, all others to WRITE.
  - WRITE to WAIT.
- Per-state outputs (Moore, decoded from state and IR only). Every output not listed is 0; readnum and writenum default to 000.
  - WAIT: w=1.
  - WIMM: writenum=Rn, vsel=10, write=1.
  - GETA: readnum=Rn, loada=1.
  - GETB: readnum=Rm, loadb=1.
  - EXEC:
    - MOV reg: asel=1, ALUop=00, loadc=1.
    - CMP: ALUop=01, loads=1.
    - ADD/AND/MVN: ALUop=op, loadc=1.
  - WRITE: writenum=Rd, vsel=00, write=1.
- IR loads on a rising edge where state is WAIT and `load`=1. `load` in any other state is ignored.
- `s` outside WAIT is ignored; it is not queued.

## Timing
- Reset values: state WAIT, IR 0000. Outputs therefore reset to w=1, all strobes 0, readnum=writenum=000, vsel=00, ALUop=00, shift=00, sximm8=sximm5=0000.
- Reset mid-instruction forces WAIT immediately (asynchronous). Strobes drop in the same cycle and no partial write follows.
- Cycles from the edge that samples `s` until w=1 again:
  - MOV imm: 2.
  - MOV reg, MVN, CMP: 4.
  - ADD, AND: 5.
  - Illegal: 1.
- `load` and `s` high on the same WAIT edge: IR takes the new `in`, and DECODE decodes the new value.
- Every strobe is high for exactly one cycle per instruction.
- `write` is never high in the same cycle as any load enable.
- IR is stable from DECODE until the return to WAIT, so the fields seen by the register file cannot change mid-instruction.

## Test plan
- Reset, then load `in`=D107 (MOV R1,#7) and pulse `s`. Require:
  - WIMM with writenum=001, vsel=10, write=1, sximm8=0007.
  - w=1 two cycles after `s` is sampled.
- Load A2E8 (ADD R7,R2,R0, shift 01) and start. Require:
  - GETA with readnum=010, loada=1.
  - GETB with readnum=000, loadb=1, shift=01.
  - EXEC with loadc=1, ALUop=00.
  - WRITE with writenum=111, write=1; back to WAIT after 5 cycles.
- Load A900 (CMP R1,R0) and start. Require:
  - EXEC with loads=1, loadc=0.
  - write never asserted; w after 4 cycles.
- Load C0E3 (MOV R7,R3) and start. Require:
  - GETB with readnum=011.
  - EXEC with asel=1, ALUop=00.
  - WRITE with writenum=111.
- Illegal and ignored inputs:
  - Load E000 and start: back to WAIT after 1 cycle with no strobes.
  - Pulse `s` and `load`=1 with `in`=FFFF during GETA: IR unchanged and no restart.
- Assert reset during EXEC of an ADD. Require:
  - state WAIT, w=1, and write never asserted.
  - IR reads 0000 afterwards.
